// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : div_unit
//  Description : Multi-cycle 32-bit restoring divider for DIV/DIVU. Produces
//                one quotient bit per clock and presents {remainder,
//                quotient} with a ready flag that EX uses to release its
//                pipeline stall.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1   pipeline clock, rising edge
//    rst           in   1   asynchronous reset, active low
//    signed_div_i  in   1   1 = signed (DIV), 0 = unsigned (DIVU)
//    opdata1_i     in  32   dividend
//    opdata2_i     in  32   divisor
//    start_i       in   1   request, held by EX until result consumed
//    annul_i       in   1   abort any operation in progress
//    result_o      out 64   {remainder, quotient} -> {hi, lo}
//    ready_o       out  1   result_o valid
// ============================================================================
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BYZERO = 2'd1;
    localparam logic [1:0] ON     = 2'd2;
    localparam logic [1:0] END    = 2'd3;

    localparam logic [5:0] LAST_STEP_DONE = 6'd32;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] dividend;      // magnitude, shifted left one bit per step
    logic [31:0] divisor;       // magnitude
    logic [31:0] quotient;
    logic [31:0] rem;           // always < divisor, so 32 bits suffice
    logic        neg_dividend;
    logic        neg_divisor;

    // Operand magnitudes at acceptance; only signed requests take abs value.
    logic        op1_neg;
    logic        op2_neg;
    logic [31:0] op1_abs;
    logic [31:0] op2_abs;

    // One restoring step: bring down the next dividend bit and trial-subtract.
    logic [32:0] trial;
    logic        fits;
    logic [31:0] diff;

    // Sign-corrected final values.
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        op1_neg  = signed_div_i & opdata1_i[31];
        op2_neg  = signed_div_i & opdata2_i[31];
        op1_abs  = op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
        op2_abs  = op2_neg ? (32'd0 - opdata2_i) : opdata2_i;

        trial    = {rem, dividend[31]};
        fits     = (trial >= {1'b0, divisor});
        // When fits is set the true difference is below 2^32, so the low
        // 32 bits of the subtraction are exact.
        diff     = trial[31:0] - divisor;

        quot_fix = (neg_dividend ^ neg_divisor) ? (32'd0 - quotient) : quotient;
        rem_fix  = neg_dividend ? (32'd0 - rem) : rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= FREE;
            cnt          <= 6'd0;
            dividend     <= 32'd0;
            divisor      <= 32'd0;
            quotient     <= 32'd0;
            rem          <= 32'd0;
            neg_dividend <= 1'b0;
            neg_divisor  <= 1'b0;
            result_o     <= 64'd0;
            ready_o      <= 1'b0;
        end else if (state != FREE && annul_i) begin
            // Abort takes priority over stepping and completion alike.
            state    <= FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state        <= ON;
                            dividend     <= op1_abs;
                            divisor      <= op2_abs;
                            neg_dividend <= op1_neg;
                            neg_divisor  <= op2_neg;
                            cnt          <= 6'd0;
                            rem          <= 32'd0;
                            quotient     <= 32'd0;
                        end
                    end
                end

                BYZERO: begin
                    state    <= END;
                    result_o <= 64'd0;
                    ready_o  <= 1'b1;
                end

                ON: begin
                    if (cnt == LAST_STEP_DONE) begin
                        // All 32 steps done; this edge publishes the result.
                        state    <= END;
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                    end else begin
                        rem      <= fits ? diff : trial[31:0];
                        quotient <= {quotient[30:0], fits};
                        dividend <= {dividend[30:0], 1'b0};
                        cnt      <= cnt + 6'd1;
                    end
                end

                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end

                default: begin
                    state    <= FREE;
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_unit
//  Description : Self-checking bench for div_unit. Directed cases plus
//                randomized operands compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks;
    int failures;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, truncating division.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Start an operation, measure latency from the accepting edge, check the
    // result, hold one cycle, then release and confirm return to FREE.
    // scramble=1 changes the operand inputs while the divider is busy.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit scramble);
        int n;
        int exp_lat;
        logic [63:0] exp;
        exp     = model(a, b, s);
        exp_lat = (b == 32'd0) ? 1 : 33;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        @(posedge clk);   // accepting edge
        #1;
        n = 0;
        while (!ready_o && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (scramble && n == 5) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~signed_div_i;
            end
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " result"}, result_o, exp);
        @(posedge clk);
        #1;
        check({tag, " hold"}, {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " free"}, {result_o[62:0], ready_o}, 64'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 64'd0);
        check("reset ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        run_op("s7/-2", 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0);
        check("s7/-2 model", model(32'h7, 32'hFFFF_FFFE, 1'b1),
              {32'h0000_0001, 32'hFFFF_FFFD});
        run_op("uFFFF/16 scramble", 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 1'b1);
        run_op("div0", 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        run_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("s-7/2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        run_op("u-7/2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);

        // Annul at step 10
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1;
        check("annul ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                @(posedge clk);
                #1;
                seen = seen | ready_o;
            end
            check("annul never ready", {63'd0, seen}, 64'd0);
        end
        run_op("u100/7", 32'd100, 32'd7, 1'b0, 1'b0);

        // Annul on the completion edge must win
        @(negedge clk);
        opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (32) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        check("annul at end", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        @(posedge clk);

        // Async reset mid-ON at step 20
        @(negedge clk);
        opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'd9; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst midON result", result_o, 64'd0);
        check("rst midON ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op("after rst", 32'hDEAD_BEEF, 32'd9, 1'b0, 1'b0);

        // Async reset while a nonzero result is presented
        @(negedge clk);
        opdata1_i = 32'd77; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (34) @(posedge clk);
        #2;
        check("pre-rst end result", result_o, model(32'd77, 32'd10, 1'b0));
        rst = 1'b0;
        #1;
        check("rst end result", result_o, 64'd0);
        check("rst end ready", {63'd0, ready_o}, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic s;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), a, b, s, bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
